// File: rtl/hls_deadlock_monitor_param_if.sv
// Bundle of stall sources, controls and registered results for the deadlock monitor.
// The master side drives stall/threshold/clear; the slave side is the monitor itself.
interface hls_deadlock_monitor_param_if #(
  parameter int NUM_AXIS = 8,
  parameter int NUM_INST = 11,
  parameter int NUM_SUB  = 2,
  parameter int THRESH_W = 8,
  parameter int CNT_W    = 16
);
  localparam int SUB_W = (NUM_SUB > 0) ? NUM_SUB : 1;
  localparam int SRC_W = $clog2(NUM_AXIS + NUM_INST + 1);

  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic [SUB_W-1:0]    sub_block;
  logic [THRESH_W-1:0] threshold;
  logic                clear;
  logic                block;
  logic [SRC_W-1:0]    block_src;
  logic [CNT_W-1:0]    event_cnt;

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block, threshold, clear,
    input  block, block_src, event_cnt
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, sub_block, threshold, clear,
    output block, block_src, event_cnt
  );
endinterface

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor: folds AXIS stalls, instance block/idle status and child monitors into a
// registered block flag with persistence threshold, optional latch, offender source and event count.
module hls_deadlock_monitor_param #(
  parameter int                  NUM_AXIS  = 8,
  parameter int                  NUM_INST  = 11,
  parameter int                  NUM_SUB   = 2,
  parameter logic [NUM_AXIS-1:0] AXIS_MASK = {NUM_AXIS{1'b1}},
  parameter logic [NUM_INST-1:0] INST_MASK = {NUM_INST{1'b1}},
  parameter int                  THRESH_W  = 8,
  parameter int                  CNT_W     = 16,
  parameter int                  STICKY    = 0
) (
  input  logic clock,
  input  logic reset,
  hls_deadlock_monitor_param_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_AXIS + NUM_INST + 1);
  localparam logic [THRESH_W-1:0] STALL_MAX = '1;
  localparam logic [CNT_W-1:0]    EVENT_MAX = '1;

  logic [NUM_AXIS-1:0] axis_masked;
  logic [NUM_INST-1:0] inst_hit;
  logic                sub_hit;
  logic                cand;
  logic                set;
  logic                block_next;
  logic                rise;
  logic [SRC_W-1:0]    src_next;
  logic [THRESH_W-1:0] stall_cnt_reg;
  logic [THRESH_W-1:0] stall_cnt_next;
  logic                block_reg;
  logic [SRC_W-1:0]    block_src_reg;
  logic [CNT_W-1:0]    event_cnt_reg;

  generate
    for (genvar gi = 0; gi < NUM_AXIS; gi++) begin : g_axis
      assign axis_masked[gi] = bus.axis_block_sigs[gi] & AXIS_MASK[gi];
    end
    for (genvar gi = 0; gi < NUM_INST; gi++) begin : g_inst
      // An idle instance is never a deadlock contributor, even if it reports blocked.
      assign inst_hit[gi] = bus.inst_block_sigs[gi] & ~bus.inst_idle_sigs[gi] & INST_MASK[gi];
    end
    if (NUM_SUB > 0) begin : g_sub
      assign sub_hit = &bus.sub_block;
    end else begin : g_nosub
      assign sub_hit = 1'b0;
    end
  endgenerate

  assign cand = (|axis_masked) | (|inst_hit) | sub_hit;

  // Scanning from the top down leaves the lowest-index, highest-priority offender last.
  always_comb begin
    src_next = SRC_W'(NUM_AXIS + NUM_INST);
    for (int i = NUM_INST - 1; i >= 0; i--) begin
      if (inst_hit[i]) src_next = SRC_W'(NUM_AXIS + i);
    end
    for (int j = NUM_AXIS - 1; j >= 0; j--) begin
      if (axis_masked[j]) src_next = SRC_W'(j);
    end
  end

  always_comb begin
    stall_cnt_next = '0;
    if (cand) begin
      stall_cnt_next = (stall_cnt_reg == STALL_MAX) ? STALL_MAX : stall_cnt_reg + 1'b1;
    end
    set        = cand && (stall_cnt_next > bus.threshold);
    block_next = (STICKY != 0) ? (block_reg | set) : set;
    rise       = block_next & ~block_reg;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_reg <= '0;
      block_reg     <= 1'b0;
      block_src_reg <= '0;
      event_cnt_reg <= '0;
    end else if (bus.clear) begin
      stall_cnt_reg <= '0;
      block_reg     <= 1'b0;
      block_src_reg <= '0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
      block_reg     <= block_next;
      if (rise) begin
        block_src_reg <= src_next;
        if (event_cnt_reg != EVENT_MAX) event_cnt_reg <= event_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.block     = block_reg;
  assign bus.block_src = block_src_reg;
  assign bus.event_cnt = event_cnt_reg;
endmodule
